// File: rtl/bitserial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands LSB-first.
// Optional macro SERADD_SUB_EN turns sub_i into a subtract select (A + ~B + 1).
module bitserial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERADD_SUB_EN
    // Subtraction is A + ~B + 1, so cin_i is overridden while subtracting.
    assign b_load   = sub_i ? ~b_i : b_i;
    assign cin_load = sub_i | cin_i;
`else
    logic sub_unused;
    assign sub_unused = sub_i;
    assign b_load     = b_i;
    assign cin_load   = cin_i;
`endif

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (last_bit) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath; published results move only on the RUN->DONE edge.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_d     = a_i;
                        b_d     = b_load;
                        carry_d = cin_load;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    psum_d  = {sum_bit, psum_q[WIDTH-1:1]};
                    carry_d = carry_nxt;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB.
                        sum_d  = {sum_bit, psum_q[WIDTH-1:1]};
                        cout_d = carry_nxt;
                        ovf_d  = carry_q ^ carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
        sum_o  = sum_q;
        cout_o = cout_q;
        ovf_o  = ovf_q;
    end

endmodule

// File: tb/tb_bitserial_adder.sv
// Directed bench for bitserial_adder (WIDTH=8) with an arithmetic reference model checked every cycle.
module tb_bitserial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         sub_i = 1'b0;
    logic         busy_o, done_o, cout_o, ovf_o;
    logic [W-1:0] sum_o;

    int errors = 0;
    int checks = 0;

    bitserial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_i(start_i),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o),
        .cout_o(cout_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic result, published after W enabled cycles.
    logic         m_busy, m_done, m_cout, m_ovf, p_cout, p_ovf;
    logic [W-1:0] m_sum, p_sum;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_sum  <= '0;   m_cout <= 1'b0; m_ovf  <= 1'b0;
            p_sum  <= '0;   p_cout <= 1'b0; p_ovf  <= 1'b0;
        end else if (ena) begin
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b0 | 1'b1;
                    m_sum  <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
                end
                m_left <= m_left - 1;
            end else if (start_i) begin
                logic [W:0]   full;
                logic         do_sub;
`ifdef SERADD_SUB_EN
                do_sub = sub_i;
`else
                do_sub = 1'b0;
`endif
                if (do_sub) begin
                    full   = {1'b0, a_i} - {1'b0, b_i};
                    p_cout <= (a_i >= b_i);
                    p_ovf  <= (a_i[W-1] != b_i[W-1]) && (full[W-1] != a_i[W-1]);
                end else begin
                    full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
                    p_cout <= full[W];
                    p_ovf  <= (a_i[W-1] == b_i[W-1]) && (full[W-1] != a_i[W-1]);
                end
                p_sum  <= full[W-1:0];
                m_busy <= 1'b1;
                m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy_o}, {31'd0, m_busy});
        check("done", {31'd0, done_o}, {31'd0, m_done});
        check("sum",  {24'd0, sum_o},  {24'd0, m_sum});
        check("cout", {31'd0, cout_o}, {31'd0, m_cout});
        check("ovf",  {31'd0, ovf_o},  {31'd0, m_ovf});
    end

    // Accept one operation, optionally toggle ena or re-pulse start mid-run, then check literals.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                          input bit toggle, input bit restart, input int exp_lat,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int cycles;
        @(posedge clk); #1;
        ena = 1'b1; a_i = a; b_i = b; cin_i = c; sub_i = s; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cycles = 1;
        while (!done_o && cycles < 100) begin
            if (toggle) ena = cycles[0] ? 1'b0 : 1'b1;
            if (restart && cycles == 3) begin
                start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start_i = 1'b0;
        check("latency", cycles, exp_lat);
        check("lit_sum",  {24'd0, sum_o},  {24'd0, es});
        check("lit_cout", {31'd0, cout_o}, {31'd0, ec});
        check("lit_ovf",  {31'd0, ovf_o},  {31'd0, eo});
        ena = 1'b1;
        @(posedge clk); #1;
        check("done_single", {31'd0, done_o}, 32'd0);
        check("idle_busy",   {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #12;
        check("rst_sum",  {24'd0, sum_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 0, 9,  8'h10, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, 9,  8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, 0, 0, 9,  8'h80, 1'b0, 1'b1);
        run_op(8'h3C, 8'h0A, 1'b0, 1'b0, 1, 0, 17, 8'h46, 1'b0, 1'b0);
        run_op(8'h21, 8'h12, 1'b0, 1'b0, 0, 1, 9,  8'h33, 1'b0, 1'b0);

        // Abort mid-run with reset: outputs clear at once, no completion.
        @(posedge clk); #1;
        a_i = 8'h11; b_i = 8'h22; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum",  {24'd0, sum_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(8'h40, 8'h41, 1'b1, 1'b0, 0, 0, 9, 8'h82, 1'b0, 1'b1);

`ifdef SERADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 0, 9, 8'hFE, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 0, 9, 8'h7F, 1'b1, 1'b1);
        run_op(8'h09, 8'h03, 1'b0, 1'b0, 0, 0, 9, 8'h0C, 1'b0, 1'b0);
`else
        // Without the feature sub_i must be ignored.
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 0, 9, 8'h0C, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
